seq_divider_param: RTL and testbench
====================================

# seq_divider_param

Parametrised restoring sequential divider for the synthesizer datapath. It converts wide dividends, such as clock-rate constants, by 16-bit divisors such as note frequencies, and produces the quotient and remainder used for tone counters and phase increments. It resolves one quotient bit per cycle and uses a start/busy/done handshake. Divide-by-zero is detected and reported, and an in-flight division can be aborted synchronously.

## Interface
- N_WIDTH, 24, dividend and quotient width; must be ≥ D_WIDTH and ≥ 2
- D_WIDTH, 16, divisor and remainder width; must be ≥ 1
- clk  in  1  system clock, rising edge
- nRst  in  1  asynchronous, active-low reset
- start  in  1  request a division; sampled only in IDLE
- abort  in  1  synchronous cancel; forces IDLE, no done pulse
- dividend  in  N_WIDTH  unsigned numerator; captured on accepted start
- divisor  in  D_WIDTH  unsigned denominator; captured on accepted start
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse when results are valid
- quotient  out  N_WIDTH  registered result; holds until next completion
- remainder  out  D_WIDTH  registered result; holds until next completion
- div_by_zero  out  1  registered flag for the last completed division

## Operation
- States: IDLE, DIVIDE, DONE.
- Reset (nRst low, async) behaviour:
  - state = IDLE; internal registers and bit counter cleared.
  - quotient = 0, remainder = 0, busy = 0, done = 0, div_by_zero = 0.
- IDLE:
  - start = 1 and abort = 0 accepts a request: dividend and divisor are latched into a working quotient shift register and divisor register.
  - The partial remainder (D_WIDTH+1 bits) and the bit counter are cleared.
  - Next state is DIVIDE, or DONE if the divisor is 0.
  - start is ignored outside IDLE. No queuing.
- DIVIDE, one iteration per cycle, MSB first:
  - Form trial = {partial_rem[D_WIDTH-1:0], work_q MSB}.
  - If trial ≥ divisor, partial_rem = trial − divisor and shift 1 into work_q LSB.
  - Otherwise partial_rem = trial and shift 0 into work_q LSB.
  - The counter increments. After exactly N_WIDTH iterations, go to DONE.
- Entering DONE (same edge as the last iteration):
  - quotient = work_q, remainder = partial_rem[D_WIDTH-1:0], div_by_zero = 0.
- Divide-by-zero path (divisor = 0 at start):
  - DIVIDE is skipped.
  - quotient = all ones, remainder = 0, div_by_zero = 1.
- DONE: done = 1 for this single cycle. The next state is always IDLE.
- abort = 1 in any state: next state is IDLE.
  - The working registers are discarded.
  - quotient, remainder and div_by_zero keep their previous values.
  - done does not assert. If the state is DONE when abort arrives, done still asserts for that cycle.
- abort and start in the same IDLE cycle: abort wins and start is dropped.
- Results are unsigned and exact: dividend = quotient × divisor + remainder, with remainder < divisor.

## Timing
- Start accepted at edge E.
  - Normal case: done is high in the cycle after edge E+N_WIDTH, so latency is N_WIDTH+1 cycles (25 by default).
  - Divide-by-zero: done is high in the cycle after edge E, so latency is 1 cycle.
- busy rises in the cycle after E and falls in the cycle after done.
- A new start can be accepted in the first IDLE cycle, so throughput is one result per N_WIDTH+2 cycles.
- quotient, remainder and div_by_zero change only on the edge that enters DONE. They are stable while done is high and after it.
- Asynchronous reset mid-operation: the outputs clear immediately and no done pulse follows.
- No combinational path from inputs to outputs.

## Test plan
- Defaults, dividend = 1000000, divisor = 440 → done 25 cycles after start; quotient = 2272, remainder = 320, div_by_zero = 0.
- dividend = 24'hFFFFFF, divisor = 1 → quotient = 24'hFFFFFF, remainder = 0. Also dividend = 5, divisor = 7 → quotient = 0, remainder = 5.
- divisor = 0, dividend = 1234 → done 1 cycle after start; quotient = 24'hFFFFFF, remainder = 0, div_by_zero = 1. A following 100/10 → quotient = 10, remainder = 0, div_by_zero = 0.
- Start 1000000/440, then pulse start with 50/5 at cycle 5 while busy → the second request is ignored; a single done with quotient = 2272.
- Start 1000000/440, then abort at cycle 10 → busy low next cycle; no done; quotient/remainder keep prior values. Also drop nRst at cycle 12 of a new division → all outputs 0 immediately.
- Randomized sweep with N_WIDTH = 8, D_WIDTH = 4 over all 4096 operand pairs → matches a reference model; latency is 9 cycles for every nonzero divisor.

Source files
------------

// File: rtl/seq_divider_param.sv
// Restoring sequential divider: one quotient bit per cycle, MSB first,
// with a start/busy/done handshake, divide-by-zero flag and synchronous abort.
module seq_divider_param #(
    parameter int N_WIDTH = 24,
    parameter int D_WIDTH = 16
) (
    input  logic               clk,
    input  logic               nRst,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [N_WIDTH-1:0] dividend_i,
    input  logic [D_WIDTH-1:0] divisor_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [N_WIDTH-1:0] quotient_o,
    output logic [D_WIDTH-1:0] remainder_o,
    output logic               div_by_zero_o
);

    localparam int CW = (N_WIDTH > 2) ? $clog2(N_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(N_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [N_WIDTH-1:0] work_q, work_d;   // dividend shifts out, quotient shifts in
    logic [D_WIDTH-1:0] dvsr_q, dvsr_d;
    logic [D_WIDTH-1:0] prem_q, prem_d;   // partial remainder, always < divisor
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [N_WIDTH-1:0] quot_q, quot_d;
    logic [D_WIDTH-1:0] rem_q, rem_d;
    logic               dbz_q, dbz_d;

    // One restoring step. The trial value is D_WIDTH+1 bits wide; because the
    // partial remainder is below the divisor, trial - divisor fits in D_WIDTH bits.
    logic [D_WIDTH:0]   trial;
    logic               ge;
    logic [D_WIDTH-1:0] prem_nx;
    logic [N_WIDTH-1:0] work_nx;

    assign trial   = {prem_q, work_q[N_WIDTH-1]};
    assign ge      = (trial >= {1'b0, dvsr_q});
    assign prem_nx = ge ? (trial[D_WIDTH-1:0] - dvsr_q) : trial[D_WIDTH-1:0];
    assign work_nx = {work_q[N_WIDTH-2:0], ge};

    // Next-state and datapath control; result registers load only on entry to DONE.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        dvsr_d  = dvsr_q;
        prem_d  = prem_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    work_d = dividend_i;
                    dvsr_d = divisor_i;
                    prem_d = '0;
                    cnt_d  = '0;
                    if (divisor_i == '0) begin
                        state_d = DONE;
                        quot_d  = '1;
                        rem_d   = '0;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = DIVIDE;
                    end
                end
            end
            DIVIDE: begin
                work_d = work_nx;
                prem_d = prem_nx;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    quot_d  = work_nx;
                    rem_d   = prem_nx;
                    dbz_d   = 1'b0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort beats everything: drop the working set, keep the last results.
        if (abort_i) begin
            state_d = IDLE;
            work_d  = '0;
            dvsr_d  = '0;
            prem_d  = '0;
            cnt_d   = '0;
            quot_d  = quot_q;
            rem_d   = rem_q;
            dbz_d   = dbz_q;
        end
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= IDLE;
            work_q  <= '0;
            dvsr_q  <= '0;
            prem_q  <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            dvsr_q  <= dvsr_d;
            prem_q  <= prem_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy_o        = (state_q != IDLE);
    assign done_o        = (state_q == DONE);
    assign quotient_o    = quot_q;
    assign remainder_o   = rem_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_seq_divider_param.sv
// Bench for seq_divider_param: directed vector table and corner sequences on the
// default 24/16 instance, plus a shuffled exhaustive sweep of an 8/4 instance.
module tb_seq_divider_param;

    localparam int N  = 24;
    localparam int D  = 16;
    localparam int SN = 8;
    localparam int SD = 4;

    logic clk = 1'b0;
    logic nRst;
    always #5 clk = ~clk;

    logic         start, abort;
    logic [N-1:0] a;
    logic [D-1:0] b;
    logic         busy, done, dbz;
    logic [N-1:0] q;
    logic [D-1:0] r;

    logic          s_start, s_abort;
    logic [SN-1:0] s_a;
    logic [SD-1:0] s_b;
    logic          s_busy, s_done, s_dbz;
    logic [SN-1:0] s_q;
    logic [SD-1:0] s_r;

    seq_divider_param #(.N_WIDTH(N), .D_WIDTH(D)) dut (
        .clk(clk), .nRst(nRst), .start_i(start), .abort_i(abort),
        .dividend_i(a), .divisor_i(b), .busy_o(busy), .done_o(done),
        .quotient_o(q), .remainder_o(r), .div_by_zero_o(dbz)
    );

    seq_divider_param #(.N_WIDTH(SN), .D_WIDTH(SD)) dut_s (
        .clk(clk), .nRst(nRst), .start_i(s_start), .abort_i(s_abort),
        .dividend_i(s_a), .divisor_i(s_b), .busy_o(s_busy), .done_o(s_done),
        .quotient_o(s_q), .remainder_o(s_r), .div_by_zero_o(s_dbz)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // Launch one division on the wide instance and wait (bounded) for done.
    // lat = 1 means done is seen in the cycle right after the accepting edge.
    task automatic run_big(input logic [N-1:0] x, input logic [D-1:0] y, output int lat);
        @(posedge clk); #1;
        start = 1'b1; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; a = ~x; b = ~y;   // operands must already be captured
        chk("busy_after_start", busy, 1);
        lat = 1;
        while (!done && lat < N + 10) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_small(input logic [SN-1:0] x, input logic [SD-1:0] y, output int lat);
        @(posedge clk); #1;
        s_start = 1'b1; s_a = x; s_b = y;
        @(posedge clk); #1;
        s_start = 1'b0; s_a = ~x; s_b = ~y;
        lat = 1;
        while (!s_done && lat < SN + 10) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    typedef struct {
        logic [N-1:0] a;
        logic [D-1:0] b;
        logic [N-1:0] q;
        logic [D-1:0] r;
        logic         z;
        int           lat;
    } vec_t;

    vec_t tbl[7];
    int   idx[4096];

    initial begin
        int lat, dn, first;
        logic [SN-1:0] ea;
        logic [SD-1:0] eb;
        logic [SN-1:0] eq;
        logic [SD-1:0] er;

        tbl[0] = '{24'd1000000,  16'd440,    24'd2272,     16'd320, 1'b0, 25};
        tbl[1] = '{24'hFFFFFF,   16'd1,      24'hFFFFFF,   16'd0,   1'b0, 25};
        tbl[2] = '{24'd5,        16'd7,      24'd0,        16'd5,   1'b0, 25};
        tbl[3] = '{24'd1234,     16'd0,      24'hFFFFFF,   16'd0,   1'b1, 1};
        tbl[4] = '{24'd100,      16'd10,     24'd10,       16'd0,   1'b0, 25};
        tbl[5] = '{24'hFFFFFF,   16'hFFFF,   24'd256,      16'd255, 1'b0, 25};
        tbl[6] = '{24'd0,        16'd5,      24'd0,        16'd0,   1'b0, 25};

        start = 0; abort = 0; a = '0; b = '0;
        s_start = 0; s_abort = 0; s_a = '0; s_b = '0;
        nRst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", q, 0);
        chk("rst_r", r, 0);
        chk("rst_dbz", dbz, 0);
        nRst = 1'b1;

        // Directed vectors
        for (int i = 0; i < 7; i++) begin
            run_big(tbl[i].a, tbl[i].b, lat);
            chk($sformatf("v%0d_done", i), done, 1);
            chk($sformatf("v%0d_latency", i), lat, tbl[i].lat);
            chk($sformatf("v%0d_q", i), q, tbl[i].q);
            chk($sformatf("v%0d_r", i), r, tbl[i].r);
            chk($sformatf("v%0d_dbz", i), dbz, tbl[i].z);
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_pulse", i), done, 0);
            chk($sformatf("v%0d_busy_fall", i), busy, 0);
            chk($sformatf("v%0d_q_hold", i), q, tbl[i].q);
        end

        // A start pulse while busy must be ignored
        @(posedge clk); #1;
        start = 1'b1; a = 24'd1000000; b = 16'd440;
        @(posedge clk); #1;
        start = 1'b0;
        dn = 0; first = 0;
        for (int c = 1; c <= N + 20; c++) begin
            if (c == 5) begin start = 1'b1; a = 24'd50; b = 16'd5; end
            else start = 1'b0;
            if (done) begin dn++; if (first == 0) first = c; end
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("busy_start_done_count", dn, 1);
        chk("busy_start_latency", first, 25);
        chk("busy_start_q", q, 2272);
        chk("busy_start_r", r, 320);

        // Abort mid-division keeps the previous results
        run_big(24'd5, 16'd7, lat);
        @(posedge clk); #1;
        start = 1'b1; a = 24'd1000000; b = 16'd440;
        @(posedge clk); #1;
        start = 1'b0;
        dn = 0;
        for (int c = 1; c <= N + 20; c++) begin
            abort = (c == 10);
            if (c == 11) chk("abort_busy_low", busy, 0);
            if (done) dn++;
            @(posedge clk); #1;
        end
        abort = 1'b0;
        chk("abort_no_done", dn, 0);
        chk("abort_q_kept", q, 0);
        chk("abort_r_kept", r, 5);
        chk("abort_dbz_kept", dbz, 0);

        // Abort and start together in IDLE: abort wins
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1; a = 24'd100; b = 16'd10;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("abort_start_busy", busy, 0);
        dn = 0;
        repeat (N + 5) begin
            if (done) dn++;
            @(posedge clk); #1;
        end
        chk("abort_start_no_done", dn, 0);

        // Asynchronous reset mid-division clears outputs at once
        run_big(24'd1000000, 16'd440, lat);
        chk("pre_reset_q", q, 2272);
        @(posedge clk); #1;
        start = 1'b1; a = 24'd1000; b = 16'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #3;
        nRst = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_q", q, 0);
        chk("arst_r", r, 0);
        chk("arst_dbz", dbz, 0);
        #2;
        nRst = 1'b1;
        dn = 0;
        repeat (N + 5) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        chk("arst_no_done", dn, 0);

        // Exhaustive 8/4 sweep in random order against an arithmetic model
        for (int i = 0; i < 4096; i++) idx[i] = i;
        for (int i = 4095; i > 0; i--) begin
            int j, t;
            j = $urandom_range(i, 0);
            t = idx[i]; idx[i] = idx[j]; idx[j] = t;
        end
        for (int i = 0; i < 4096; i++) begin
            ea = SN'(idx[i] >> SD);
            eb = SD'(idx[i]);
            if (eb == 0) begin
                eq = '1; er = '0;
            end else begin
                eq = ea / SN'(eb);
                er = SD'(ea % SN'(eb));
            end
            run_small(ea, eb, lat);
            chk($sformatf("sw_%0d_%0d_done", ea, eb), s_done, 1);
            chk($sformatf("sw_%0d_%0d_lat", ea, eb), lat, (eb == 0) ? 1 : SN + 1);
            chk($sformatf("sw_%0d_%0d_q", ea, eb), s_q, eq);
            chk($sformatf("sw_%0d_%0d_r", ea, eb), s_r, er);
            chk($sformatf("sw_%0d_%0d_dbz", ea, eb), s_dbz, (eb == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
